// File: rtl/cache_pkg.sv
// cache_pkg: shared sizes, controller operation encoding and priority-encode helper
package cache_pkg;
  localparam int NUM_ENTRIES = 16;
  localparam int KEY_WIDTH = 32;
  localparam int VALUE_WIDTH = 64;
  localparam int MAX_ENTRIES = 64;
  typedef enum logic [1:0] {
    NOOP  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } operation_e;
  // Wide enough for any slot count up to MAX_ENTRIES; callers zero-extend and truncate.
  function automatic logic [MAX_ENTRIES-1:0] onehot_lowest(input logic [MAX_ENTRIES-1:0] v);
    return v & (~v + 1'b1);
  endfunction
endpackage

// File: rtl/cache_slot.sv
// cache_slot: one key/value slot with used bit, key comparator and optional TTL (ENTRY_TTL_EN)
module cache_slot #(
  parameter int KEY_WIDTH = 32,
  parameter int VALUE_WIDTH = 64
`ifdef ENTRY_TTL_EN
  , parameter int TTL_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   update,
  input  logic                   clear,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  output logic                   used,
  output logic                   match,
  output logic [VALUE_WIDTH-1:0] value
);
  logic [KEY_WIDTH-1:0] key;
  logic expire;
`ifdef ENTRY_TTL_EN
  localparam int TTL_W = $clog2(TTL_CYCLES + 1);
  logic [TTL_W-1:0] ttl;
  // A write landing in the expiry cycle keeps the entry alive.
  assign expire = (ttl == TTL_W'(1)) && !(load || update);
  // Lifetime counter: reload on any write, zero on delete, otherwise count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ttl <= '0;
    else if (load || update) ttl <= TTL_W'(TTL_CYCLES);
    else if (clear) ttl <= '0;
    else if (ttl != '0) ttl <= ttl - 1'b1;
  end
`else
  assign expire = 1'b0;
`endif
  assign match = used && (key == key_in);
  // Occupancy: set by a new entry, cleared by delete or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) used <= 1'b0;
    else if (load) used <= 1'b1;
    else if (clear || expire) used <= 1'b0;
  end
  // Payload storage is deliberately left without reset; used gates its visibility.
  always_ff @(posedge clk) begin
    if (load) key <= key_in;
    if (load || update) value <= value_in;
  end
endmodule

// File: rtl/cache_entry_store.sv
// cache_entry_store: keyed slot store with write/lookup/delete and registered results; TTL via ENTRY_TTL_EN
module cache_entry_store #(
  parameter int NUM_ENTRIES = cache_pkg::NUM_ENTRIES,
  parameter int KEY_WIDTH = cache_pkg::KEY_WIDTH,
  parameter int VALUE_WIDTH = cache_pkg::VALUE_WIDTH
`ifdef ENTRY_TTL_EN
  , parameter int TTL_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ENTRIES-1:0] idx_in,
  input  logic                   write_in,
  input  logic                   select_in,
  input  logic                   delete_in,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  output logic [NUM_ENTRIES-1:0] used_out,
  output logic                   full_out,
  output logic                   valid_out,
  output logic                   hit_out,
  output logic [NUM_ENTRIES-1:0] hit_idx_out,
  output logic [VALUE_WIDTH-1:0] value_out
);
  import cache_pkg::*;
  logic [NUM_ENTRIES-1:0] match, first, load, update, clear, target;
  logic [VALUE_WIDTH-1:0] values [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] match_value, result_value;
  logic hit, idx_onehot, do_delete, do_select, stored;
  assign first = NUM_ENTRIES'(onehot_lowest(MAX_ENTRIES'(match)));
  assign hit = |match;
  assign idx_onehot = (idx_in != '0) && ((idx_in & (idx_in - 1'b1)) == '0);
  assign do_delete = delete_in && !write_in;
  assign do_select = select_in && !write_in && !delete_in;
  assign stored = hit || idx_onehot;
  assign target = hit ? first : idx_onehot ? idx_in : '0;
  assign load = (write_in && !hit && idx_onehot) ? idx_in : '0;
  assign update = (write_in && hit) ? first : '0;
  assign clear = do_delete ? first : '0;
  assign full_out = &used_out;
  // Value of the winning matched slot; zero when nothing matches.
  always_comb begin
    match_value = '0;
    for (int j = 0; j < NUM_ENTRIES; j++) match_value |= first[j] ? values[j] : '0;
  end
  assign result_value = write_in ? (stored ? value_in : '0) : match_value;
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
    cache_slot #(
      .KEY_WIDTH(KEY_WIDTH),
      .VALUE_WIDTH(VALUE_WIDTH)
`ifdef ENTRY_TTL_EN
      , .TTL_CYCLES(TTL_CYCLES)
`endif
    ) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[i]),
      .update(update[i]),
      .clear(clear[i]),
      .key_in(key_in),
      .value_in(value_in),
      .used(used_out[i]),
      .match(match[i]),
      .value(values[i])
    );
  end
  // Result register: one-cycle valid pulse for the highest-priority strobe accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      hit_out <= 1'b0;
      hit_idx_out <= '0;
      value_out <= '0;
    end else begin
      valid_out <= write_in || do_delete || do_select;
      hit_out <= write_in ? stored : hit;
      hit_idx_out <= write_in ? target : first;
      value_out <= result_value;
    end
  end
endmodule

// File: tb/tb_cache_entry_store.sv
// tb_cache_entry_store: directed scoreboard bench for cache_entry_store (ENTRY_TTL_EN selects TTL scenario)
module tb_cache_entry_store;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] idx_in = '0;
  logic write_in = 1'b0, select_in = 1'b0, delete_in = 1'b0;
  logic [31:0] key_in = '0;
  logic [63:0] value_in = '0;
  logic [15:0] used_out, hit_idx_out;
  logic full_out, valid_out, hit_out;
  logic [63:0] value_out;
  typedef struct {
    string name;
    logic hit;
    logic [15:0] idx;
    logic [63:0] val;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  cache_entry_store #(
`ifdef ENTRY_TTL_EN
    .TTL_CYCLES(4),
`endif
    .NUM_ENTRIES(16),
    .KEY_WIDTH(32),
    .VALUE_WIDTH(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .idx_in(idx_in),
    .write_in(write_in),
    .select_in(select_in),
    .delete_in(delete_in),
    .key_in(key_in),
    .value_in(value_in),
    .used_out(used_out),
    .full_out(full_out),
    .valid_out(valid_out),
    .hit_out(hit_out),
    .hit_idx_out(hit_idx_out),
    .value_out(value_out)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic op(input logic w, input logic d, input logic s, input logic [31:0] k,
                    input logic [63:0] v, input logic [15:0] idx, input string name,
                    input logic eh, input logic [15:0] ei, input logic [63:0] ev);
    exp_t e;
    write_in = w;
    delete_in = d;
    select_in = s;
    key_in = k;
    value_in = v;
    idx_in = idx;
    e.name = name;
    e.hit = eh;
    e.idx = ei;
    e.val = ev;
    q.push_back(e);
    @(posedge clk);
    #1;
    write_in = 1'b0;
    delete_in = 1'b0;
    select_in = 1'b0;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_out) begin
      if (q.size() == 0) check("unexpected_valid", 64'(valid_out), 64'd0);
      else begin
        e = q.pop_front();
        check({e.name, "_hit"}, 64'(hit_out), 64'(e.hit));
        check({e.name, "_idx"}, 64'(hit_idx_out), 64'(e.idx));
        check({e.name, "_value"}, value_out, e.val);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_used", 64'(used_out), 64'd0);
    check("rst_full", 64'(full_out), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_hit", 64'(hit_out), 64'd0);
    check("rst_idx", 64'(hit_idx_out), 64'd0);
    check("rst_value", value_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
`ifndef ENTRY_TTL_EN
    op(1, 0, 0, 32'hA5, 64'h1234, 16'h0001, "wr_new", 1, 16'h0001, 64'h1234);
    check("used_after_wr", 64'(used_out), 64'h0001);
    op(0, 0, 1, 32'hA5, 0, 0, "lk_hit", 1, 16'h0001, 64'h1234);
    op(0, 0, 1, 32'hB0, 0, 0, "lk_miss", 0, 16'h0000, 64'h0);
    op(1, 0, 0, 32'hA5, 64'h9999, 16'h0002, "wr_update", 1, 16'h0001, 64'h9999);
    check("used_after_update", 64'(used_out), 64'h0001);
    op(0, 0, 1, 32'hA5, 0, 0, "lk_updated", 1, 16'h0001, 64'h9999);
    for (int i = 1; i < 16; i++)
      op(1, 0, 0, 32'h100 + 32'(i), 64'h5000 + 64'(i), 16'(1 << i), "wr_fill", 1, 16'(1 << i), 64'h5000 + 64'(i));
    check("used_full", 64'(used_out), 64'hFFFF);
    check("full_set", 64'(full_out), 64'd1);
    op(1, 0, 0, 32'hDEAD, 64'h1, 16'h0000, "wr_idx_zero", 0, 16'h0000, 64'h0);
    check("used_after_drop", 64'(used_out), 64'hFFFF);
    op(0, 1, 0, 32'h103, 0, 0, "del_slot3", 1, 16'h0008, 64'h5003);
    check("used_after_del", 64'(used_out), 64'hFFF7);
    check("full_clear", 64'(full_out), 64'd0);
    op(0, 1, 0, 32'h103, 0, 0, "del_miss", 0, 16'h0000, 64'h0);
    op(1, 0, 0, 32'h777, 64'h7, 16'h0018, "wr_multihot", 0, 16'h0000, 64'h0);
    check("used_after_multihot", 64'(used_out), 64'hFFF7);
    op(1, 1, 0, 32'h200, 64'hABC, 16'h0008, "wr_over_del", 1, 16'h0008, 64'hABC);
    check("used_after_wr_del", 64'(used_out), 64'hFFFF);
    op(0, 0, 1, 32'h200, 0, 0, "lk_new3", 1, 16'h0008, 64'hABC);
    op(0, 1, 1, 32'h102, 0, 0, "del_over_sel", 1, 16'h0004, 64'h5002);
    check("used_after_del_sel", 64'(used_out), 64'hFFFB);
    op(0, 0, 1, 32'h102, 0, 0, "lk_deleted", 0, 16'h0000, 64'h0);
    op(1, 0, 1, 32'hA5, 64'h1, 16'h0000, "wr_over_sel", 1, 16'h0001, 64'h1);
`else
    op(1, 0, 0, 32'h42, 64'h77, 16'h0001, "ttl_wr", 1, 16'h0001, 64'h77);
    idle();
    idle();
    op(0, 0, 1, 32'h42, 0, 0, "ttl_lk_plus3", 1, 16'h0001, 64'h77);
    op(0, 0, 1, 32'h42, 0, 0, "ttl_lk_expiry", 1, 16'h0001, 64'h77);
    check("ttl_used_expired", 64'(used_out), 64'h0000);
    op(0, 0, 1, 32'h42, 0, 0, "ttl_lk_plus5", 0, 16'h0000, 64'h0);
    op(1, 0, 0, 32'h43, 64'h88, 16'h0002, "ttl_wr2", 1, 16'h0002, 64'h88);
    idle();
    idle();
    idle();
    op(1, 0, 0, 32'h43, 64'h99, 16'h0004, "ttl_wr_expiry", 1, 16'h0002, 64'h99);
    check("ttl_used_reload", 64'(used_out), 64'h0002);
    idle();
    idle();
    op(0, 0, 1, 32'h43, 0, 0, "ttl_lk_reloaded", 1, 16'h0002, 64'h99);
    op(0, 0, 1, 32'h43, 0, 0, "ttl_lk_reload_exp", 1, 16'h0002, 64'h99);
    check("ttl_used_expired2", 64'(used_out), 64'h0000);
    op(1, 0, 0, 32'h44, 64'h55, 16'h0001, "ttl_wr3", 1, 16'h0001, 64'h55);
    op(0, 1, 0, 32'h44, 0, 0, "ttl_del", 1, 16'h0001, 64'h55);
    check("ttl_used_del", 64'(used_out), 64'h0000);
`endif
    op(1, 0, 0, 32'h50, 64'h5, 16'h0004, "wr_pre_reset", 1, 16'h0004, 64'h5);
    idle();
    select_in = 1'b1;
    key_in = 32'h50;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    select_in = 1'b0;
    check("midrst_valid", 64'(valid_out), 64'd0);
    check("midrst_used", 64'(used_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("postrst_valid", 64'(valid_out), 64'd0);
    op(0, 0, 1, 32'h50, 0, 0, "lk_after_rst", 0, 16'h0000, 64'h0);
    repeat (3) idle();
    check("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
